// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes a MIPS instruction into ALU operands and aluctr behind a valid/ready register slice.
// Optional macro ISSUE_ILLEGAL_TRAP_EN: flag undecodable instructions on out_illegal instead of issuing a silent nop.
module alu_issue_stage #(
    parameter int DW = 32,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   instr,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    input  logic [1:0]    fwd_a_sel,
    input  logic [1:0]    fwd_b_sel,
    input  logic [DW-1:0] exmem_res,
    input  logic [DW-1:0] memwb_res,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [CW-1:0] aluctr,
    output logic          is_branch,
    output logic          out_illegal
);

    localparam logic [CW-1:0] ALU_ADD  = 5'b00000;
    localparam logic [CW-1:0] ALU_SUB  = 5'b00001;
    localparam logic [CW-1:0] ALU_SLT  = 5'b00010;
    localparam logic [CW-1:0] ALU_AND  = 5'b00011;
    localparam logic [CW-1:0] ALU_NOR  = 5'b00100;
    localparam logic [CW-1:0] ALU_OR   = 5'b00101;
    localparam logic [CW-1:0] ALU_XOR  = 5'b00110;
    localparam logic [CW-1:0] ALU_SLL  = 5'b00111;
    localparam logic [CW-1:0] ALU_SLTU = 5'b01000;
    localparam logic [CW-1:0] ALU_SRA  = 5'b01001;
    localparam logic [CW-1:0] ALU_SRL  = 5'b01010;
    localparam logic [CW-1:0] ALU_BGEZ = 5'b10000;
    localparam logic [CW-1:0] ALU_BGTZ = 5'b10001;
    localparam logic [CW-1:0] ALU_BLEZ = 5'b10010;
    localparam logic [CW-1:0] ALU_BLTZ = 5'b10011;
    localparam logic [CW-1:0] ALU_LUI  = 5'b10100;
    localparam logic [CW-1:0] ALU_SRAV = 5'b10101;
    localparam logic [CW-1:0] ALU_BNE  = 5'b10110;
    localparam logic [CW-1:0] ALU_JR   = 5'b10111;

    typedef enum logic [1:0] {A_ZERO, A_SRC, A_SHAMT, A_SHVAR} a_mode_e;
    typedef enum logic [1:0] {B_ZERO, B_SRC, B_SEXT, B_ZEXT}   b_mode_e;

    logic [5:0]    op;
    logic [5:0]    funct;
    logic [4:0]    rt;
    logic [4:0]    shamt;
    logic [15:0]   imm;
    logic          unused_rs;

    assign op        = instr[31:26];
    assign rt        = instr[20:16];
    assign shamt     = instr[10:6];
    assign funct     = instr[5:0];
    assign imm       = instr[15:0];
    assign unused_rs = ^instr[25:21];

    logic [DW-1:0] src_a;
    logic [DW-1:0] src_b;

    always_comb begin
        case (fwd_a_sel)
            2'd1:    src_a = exmem_res;
            2'd2:    src_a = memwb_res;
            default: src_a = rs_data;
        endcase
        case (fwd_b_sel)
            2'd1:    src_b = exmem_res;
            2'd2:    src_b = memwb_res;
            default: src_b = rt_data;
        endcase
    end

    a_mode_e       a_mode;
    b_mode_e       b_mode;
    logic [CW-1:0] dec_ctr;
    logic          dec_br;
    logic          dec_ill;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        a_mode  = A_SRC;
        b_mode  = B_ZERO;
        dec_ctr = ALU_ADD;
        dec_br  = 1'b0;
        dec_ill = 1'b0;
        case (op)
            6'h00: begin
                b_mode = B_SRC;
                case (funct)
                    6'h20, 6'h21: dec_ctr = ALU_ADD;
                    6'h22, 6'h23: dec_ctr = ALU_SUB;
                    6'h2A:        dec_ctr = ALU_SLT;
                    6'h2B:        dec_ctr = ALU_SLTU;
                    6'h24:        dec_ctr = ALU_AND;
                    6'h25:        dec_ctr = ALU_OR;
                    6'h26:        dec_ctr = ALU_XOR;
                    6'h27:        dec_ctr = ALU_NOR;
                    6'h00: begin dec_ctr = ALU_SLL;  a_mode = A_SHAMT; end
                    6'h02: begin dec_ctr = ALU_SRL;  a_mode = A_SHAMT; end
                    6'h03: begin dec_ctr = ALU_SRA;  a_mode = A_SHAMT; end
                    6'h04: begin dec_ctr = ALU_SLL;  a_mode = A_SHVAR; end
                    6'h06: begin dec_ctr = ALU_SRL;  a_mode = A_SHVAR; end
                    6'h07: begin dec_ctr = ALU_SRAV; a_mode = A_SHVAR; end
                    6'h08, 6'h09: begin dec_ctr = ALU_JR; b_mode = B_ZERO; end
                    default: dec_ill = 1'b1;
                endcase
            end
            6'h01: begin
                dec_br = 1'b1;
                case (rt)
                    5'd1:    dec_ctr = ALU_BGEZ;
                    5'd0:    dec_ctr = ALU_BLTZ;
                    default: dec_ill = 1'b1;
                endcase
            end
            6'h02, 6'h03: a_mode = A_ZERO;
            6'h04: begin dec_ctr = ALU_SUB;  b_mode = B_SRC; dec_br = 1'b1; end
            6'h05: begin dec_ctr = ALU_BNE;  b_mode = B_SRC; dec_br = 1'b1; end
            6'h06: begin dec_ctr = ALU_BLEZ; dec_br = 1'b1; end
            6'h07: begin dec_ctr = ALU_BGTZ; dec_br = 1'b1; end
            6'h08, 6'h09, 6'h23, 6'h2B: b_mode = B_SEXT;
            6'h0A: begin dec_ctr = ALU_SLT;  b_mode = B_SEXT; end
            6'h0B: begin dec_ctr = ALU_SLTU; b_mode = B_SEXT; end
            6'h0C: begin dec_ctr = ALU_AND;  b_mode = B_ZEXT; end
            6'h0D: begin dec_ctr = ALU_OR;   b_mode = B_ZEXT; end
            6'h0E: begin dec_ctr = ALU_XOR;  b_mode = B_ZEXT; end
            6'h0F: begin dec_ctr = ALU_LUI;  b_mode = B_ZEXT; a_mode = A_ZERO; end
            default: dec_ill = 1'b1;
        endcase
        // Anything undecodable leaves the stage as a harmless add of zeros.
        if (dec_ill) begin
            a_mode  = A_ZERO;
            b_mode  = B_ZERO;
            dec_ctr = ALU_ADD;
            dec_br  = 1'b0;
        end
    end

    logic [DW-1:0] dec_a;
    logic [DW-1:0] dec_b;

    always_comb begin
        case (a_mode)
            A_SRC:   dec_a = src_a;
            A_SHAMT: dec_a = {{(DW-5){1'b0}}, shamt};
            A_SHVAR: dec_a = {{(DW-5){1'b0}}, src_a[4:0]};
            default: dec_a = '0;
        endcase
        case (b_mode)
            B_SRC:   dec_b = src_b;
            B_SEXT:  dec_b = {{(DW-16){imm[15]}}, imm};
            B_ZEXT:  dec_b = {{(DW-16){1'b0}}, imm};
            default: dec_b = '0;
        endcase
    end

    logic xfer;

    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            out_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            aluctr    <= '0;
            is_branch <= 1'b0;
        end else if (flush) begin
            // Data registers keep their contents; only the valid bit is killed.
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            alu_a     <= dec_a;
            alu_b     <= dec_b;
            aluctr    <= dec_ctr;
            is_branch <= dec_br;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ISSUE_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_illegal <= 1'b0;
        end else if (!flush && xfer) begin
            out_illegal <= dec_ill;
        end
    end
`else
    assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic [1:0]  fwd_a_sel = '0;
    logic [1:0]  fwd_b_sel = '0;
    logic [31:0] exmem_res = '0;
    logic [31:0] memwb_res = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  aluctr;
    logic        is_branch;
    logic        out_illegal;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DW(32), .CW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rs_data(rs_data), .rt_data(rt_data), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .exmem_res(exmem_res), .memwb_res(memwb_res), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b), .aluctr(aluctr),
        .is_branch(is_branch), .out_illegal(out_illegal)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  ctr;
        logic        br;
        logic        ill;
    } exp_t;

    typedef logic [71:0] vec_t;

`ifdef ISSUE_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    function automatic vec_t pack(input logic v, input exp_t e);
        return {v, e.a, e.b, e.ctr, e.br, e.ill};
    endfunction

    function automatic vec_t obs();
        return {out_valid, alu_a, alu_b, aluctr, is_branch, out_illegal};
    endfunction

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [4:0] c,
                                input logic br, input logic ill);
        exp_t e;
        e.a = a; e.b = b; e.ctr = c; e.br = br; e.ill = ill;
        return e;
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r);
        if (s == 2'd1) return exmem_res;
        if (s == 2'd2) return memwb_res;
        return r;
    endfunction

    // Reference: what the ALU should be told for one instruction, given the forwarded sources.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] sa, input logic [31:0] sb);
        exp_t e;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] zext;
        logic [31:0] sext;
        bit known;
        op   = ins[31:26];
        fn   = ins[5:0];
        zext = {16'h0, ins[15:0]};
        sext = zext - (ins[15] ? 32'h0001_0000 : 32'h0);
        known = 1'b1;
        e = mk(sa, 32'h0, 5'd0, 1'b0, 1'b0);
        case (op)
            6'h00: begin
                e.b = sb;
                case (fn)
                    6'h20, 6'h21: e.ctr = 5'd0;
                    6'h22, 6'h23: e.ctr = 5'd1;
                    6'h2A: e.ctr = 5'd2;
                    6'h24: e.ctr = 5'd3;
                    6'h27: e.ctr = 5'd4;
                    6'h25: e.ctr = 5'd5;
                    6'h26: e.ctr = 5'd6;
                    6'h2B: e.ctr = 5'd8;
                    6'h00: begin e.ctr = 5'd7;  e.a = 32'(ins[10:6]); end
                    6'h03: begin e.ctr = 5'd9;  e.a = 32'(ins[10:6]); end
                    6'h02: begin e.ctr = 5'd10; e.a = 32'(ins[10:6]); end
                    6'h04: begin e.ctr = 5'd7;  e.a = sa % 32; end
                    6'h07: begin e.ctr = 5'd21; e.a = sa % 32; end
                    6'h06: begin e.ctr = 5'd10; e.a = sa % 32; end
                    6'h08, 6'h09: begin e.ctr = 5'd23; e.b = 32'h0; end
                    default: known = 1'b0;
                endcase
            end
            6'h08, 6'h09, 6'h23, 6'h2B: e.b = sext;
            6'h0A: begin e.ctr = 5'd2; e.b = sext; end
            6'h0B: begin e.ctr = 5'd8; e.b = sext; end
            6'h0C: begin e.ctr = 5'd3; e.b = zext; end
            6'h0D: begin e.ctr = 5'd5; e.b = zext; end
            6'h0E: begin e.ctr = 5'd6; e.b = zext; end
            6'h0F: begin e.ctr = 5'd20; e.a = 32'h0; e.b = zext; end
            6'h04: begin e.ctr = 5'd1;  e.b = sb; e.br = 1'b1; end
            6'h05: begin e.ctr = 5'd22; e.b = sb; e.br = 1'b1; end
            6'h06: begin e.ctr = 5'd18; e.br = 1'b1; end
            6'h07: begin e.ctr = 5'd17; e.br = 1'b1; end
            6'h01: begin
                e.br = 1'b1;
                if (ins[20:16] == 5'd1) e.ctr = 5'd16;
                else if (ins[20:16] == 5'd0) e.ctr = 5'd19;
                else known = 1'b0;
            end
            6'h02, 6'h03: e.a = 32'h0;
            default: known = 1'b0;
        endcase
        if (!known) e = mk(32'h0, 32'h0, 5'd0, 1'b0, TRAP);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  fl [16];
        fl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h2B, 6'h24, 6'h25,
               6'h26, 6'h27, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
        w = $urandom;
        case ($urandom_range(0, 5))
            0: begin w[31:26] = 6'h00; w[5:0] = fl[4'($urandom_range(0, 15))]; end
            1: begin w[31:26] = 6'h00; if ($urandom_range(0, 1) == 1) w[5:0] = 6'($urandom_range(8, 9)); end
            2: begin w[31:26] = 6'h01; w[20:16] = 5'($urandom_range(0, 2)); end
            3: w[31:26] = ($urandom_range(0, 1) == 1) ? 6'h23 : 6'h2B;
            4: w[31:26] = 6'($urandom_range(2, 15));
            default: ;
        endcase
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [1:0] fa, input logic [1:0] fb);
        instr = ins; rs_data = rs; rt_data = rt; fwd_a_sel = fa; fwd_b_sel = fb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (obs() !== pack(1'b0, mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0)))
            $display("FAIL reset_outputs: got %h expected %h", obs(), pack(1'b0, mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0)));
        else passes++;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else passes++;
        rst = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_addiu();
        vec_t exp;
        issue(32'h2528FFFF, 32'd5, 32'h0, 2'd0, 2'd0);
        exp = pack(1'b1, mk(32'd5, 32'hFFFFFFFF, 5'b00000, 1'b0, 1'b0));
        checks++;
        if (obs() !== exp) $display("FAIL addiu: got %h expected %h", obs(), exp);
        else passes++;
    endtask

    task automatic test_shift();
        vec_t exp;
        issue(32'h00094100, 32'h77, 32'd3, 2'd0, 2'd0);
        exp = pack(1'b1, mk(32'd4, 32'd3, 5'b00111, 1'b0, 1'b0));
        checks++;
        if (obs() !== exp) $display("FAIL sll: got %h expected %h", obs(), exp);
        else passes++;
        issue(32'h01494004, 32'h25, 32'd3, 2'd0, 2'd0);
        exp = pack(1'b1, mk(32'd5, 32'd3, 5'b00111, 1'b0, 1'b0));
        checks++;
        if (obs() !== exp) $display("FAIL sllv: got %h expected %h", obs(), exp);
        else passes++;
    endtask

    task automatic test_forward();
        vec_t exp;
        exmem_res = 32'h10;
        memwb_res = 32'h3;
        issue(32'h01094023, 32'hAAAA, 32'hBBBB, 2'd1, 2'd2);
        exp = pack(1'b1, mk(32'h10, 32'h3, 5'b00001, 1'b0, 1'b0));
        checks++;
        if (obs() !== exp) $display("FAIL forward_subu: got %h expected %h", obs(), exp);
        else passes++;
    endtask

    task automatic test_backpressure();
        vec_t exp_ori;
        vec_t exp_xori;
        exp_ori  = pack(1'b1, mk(32'h1234, 32'h0000F0F0, 5'b00101, 1'b0, 1'b0));
        exp_xori = pack(1'b1, mk(32'h5555, 32'h000000FF, 5'b00110, 1'b0, 1'b0));
        issue(32'h3508F0F0, 32'h1234, 32'h0, 2'd0, 2'd0);
        instr = 32'h390900FF; rs_data = 32'h5555;
        in_valid = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready);
            else passes++;
            tick();
            checks++;
            if (obs() !== exp_ori) $display("FAIL stall_hold[%0d]: got %h expected %h", i, obs(), exp_ori);
            else passes++;
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (obs() !== exp_xori) $display("FAIL stall_release: got %h expected %h", obs(), exp_xori);
        else passes++;
        tick();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL drain: got %b expected 0", out_valid);
        else passes++;
    endtask

    task automatic test_flush();
        vec_t exp;
        issue(32'h2528FFFF, 32'd9, 32'h0, 2'd0, 2'd0);
        instr = 32'h15090003; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL flush_with_xfer: got %b expected 0", out_valid);
        else passes++;
        issue(32'hFC001234, 32'h99, 32'h88, 2'd0, 2'd0);
        exp = pack(1'b1, mk(32'h0, 32'h0, 5'b00000, 1'b0, TRAP));
        checks++;
        if (obs() !== exp) $display("FAIL illegal_op3f: got %h expected %h", obs(), exp);
        else passes++;
        out_ready = 1'b0;
        issue(32'h15090003, 32'h1, 32'h2, 2'd0, 2'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL flush_stalled: got %b expected 0", out_valid);
        else passes++;
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        issue(32'h15090003, 32'h31, 32'h42, 2'd0, 2'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (obs() !== pack(1'b0, mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0)))
            $display("FAIL reset_mid_stall: got %h expected zeros", obs());
        else passes++;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_mid_stall_ready: got %b expected 1", in_ready);
        else passes++;
        out_ready = 1'b1;
    endtask

    task automatic test_random(input int n);
        bit   m_valid;
        bit   rdy;
        exp_t m_exp;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        tick();
        m_valid = 1'b0;
        m_exp = mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            instr     = rand_instr();
            rs_data   = $urandom;
            rt_data   = $urandom;
            exmem_res = $urandom;
            memwb_res = $urandom;
            fwd_a_sel = 2'($urandom_range(0, 3));
            fwd_b_sel = 2'($urandom_range(0, 3));
            #1;
            rdy = !m_valid || out_ready;
            checks++;
            if (in_ready !== rdy) $display("FAIL rand_in_ready[%0d]: got %b expected %b", i, in_ready, rdy);
            else passes++;
            if (flush) m_valid = 1'b0;
            else if (in_valid && rdy) begin
                m_valid = 1'b1;
                m_exp = ref_decode(instr, pick(fwd_a_sel, rs_data), pick(fwd_b_sel, rt_data));
            end else if (out_ready) m_valid = 1'b0;
            tick();
            checks++;
            if (out_valid !== m_valid) $display("FAIL rand_valid[%0d]: got %b expected %b", i, out_valid, m_valid);
            else passes++;
            if (m_valid) begin
                checks++;
                if (obs() !== pack(1'b1, m_exp))
                    $display("FAIL rand_data[%0d]: got %h expected %h", i, obs(), pack(1'b1, m_exp));
                else passes++;
            end
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_addiu();
        test_shift();
        test_forward();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        test_random(600);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
